// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader.
//   HEADER_BYTE          : frame start marker
//   DEFAULT_CLKS_PER_BIT : 115200 baud from a 50 MHz clock
//   load_state_t         : frame FSM states
//   rx_state_t           : UART receiver states
package prog_loader_pkg;

  localparam logic [7:0]  HEADER_BYTE          = 8'hA5;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
//   clock, reset : system clock, async active-low reset
//   rx           : asynchronous serial line, idles high
//   byte_out     : last received byte (valid while byte_valid pulses)
//   byte_valid   : one-cycle pulse, good stop bit
//   frame_err    : one-cycle pulse, stop bit sampled low
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_nxt;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             half_tick, bit_tick;

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync)            state_nxt = RX_START;
      // a start bit that has gone high again by mid-bit is a glitch
      RX_START: if (half_tick)                      state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7)    state_nxt = RX_STOP;
      RX_STOP:  if (bit_tick)                       state_nxt = RX_IDLE;
      default:                                      state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == RX_IDLE || state != state_nxt || (state == RX_DATA && bit_tick))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state == RX_START)
        bit_idx <= '0;

      if (state == RX_DATA && bit_tick) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == RX_STOP && bit_tick) begin
        if (rx_sync) begin
          byte_out   <= shift;
          byte_valid <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over UART and writes
// 32-bit words into instruction memory.
//   clock, reset      : system clock, async active-low reset
//   rx                : UART line from host
//   wr_en/addr/data   : one-cycle word write to instruction memory
//   busy              : frame in progress
//   done / err        : last frame good / bad, held until next header
//   words_loaded      : words written in current or last frame
// Frame: A5, LEN_HI, LEN_LO, LEN*4 data bytes (words big-endian), CSUM
// where CSUM is the XOR of the data bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned MAX_WORDS    = 256,
  parameter int unsigned TIMEOUT_CLKS = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]      rx_byte;
  logic            byte_valid, frame_err;

  load_state_t     state, state_nxt;
  logic [7:0]      len_hi;
  logic [15:0]     len_q;
  logic [15:0]     len_n;
  logic [1:0]      byte_idx;
  logic [23:0]     word_sr;
  logic [7:0]      csum;
  logic [TO_W-1:0] to_cnt;
  logic            timeout, in_frame, start_frame, last_word;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign len_n     = {len_hi, rx_byte};
  assign timeout   = (to_cnt == TO_W'(TIMEOUT_CLKS));
  assign last_word = wr_en && (words_loaded + 16'd1 == len_q);

  always_comb begin
    in_frame    = 1'b0;
    start_frame = 1'b0;
    state_nxt   = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (byte_valid && rx_byte == HEADER_BYTE) begin
          start_frame = 1'b1;
          state_nxt   = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        in_frame = 1'b1;
        if (byte_valid) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_frame = 1'b1;
        if (byte_valid) begin
          if (len_n > 16'(MAX_WORDS)) state_nxt = ST_ERR;
          else if (len_n == 16'd0)    state_nxt = ST_CSUM;
          else                        state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        in_frame = 1'b1;
        // leave DATA on the strobe of the final word so the strobe stays inside DATA
        if (last_word) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        in_frame = 1'b1;
        if (byte_valid) state_nxt = (rx_byte == csum) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (in_frame && (frame_err || timeout))
      state_nxt = ST_ERR;
  end

  always_comb begin
    busy = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
           (state == ST_DATA)   || (state == ST_CSUM);
    done = (state == ST_DONE);
    err  = (state == ST_ERR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wr_en        <= 1'b0;
      wr_addr      <= ADDR_W'(BASE_ADDR);
      wr_data      <= '0;
      words_loaded <= '0;
      len_hi       <= '0;
      len_q        <= '0;
      byte_idx     <= '0;
      word_sr      <= '0;
      csum         <= '0;
      to_cnt       <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;

      if (!in_frame || byte_valid)
        to_cnt <= '0;
      else if (!timeout)
        to_cnt <= to_cnt + TO_W'(1);

      if (start_frame) begin
        csum         <= '0;
        words_loaded <= '0;
        wr_addr      <= ADDR_W'(BASE_ADDR);
        byte_idx     <= '0;
      end

      if (state == ST_LEN_HI && byte_valid)
        len_hi <= rx_byte;

      if (state == ST_LEN_LO && byte_valid) begin
        len_q    <= len_n;
        byte_idx <= '0;
      end

      // gated on staying in DATA so an error in the same cycle cannot
      // produce a strobe outside DATA
      if (state == ST_DATA && byte_valid && state_nxt == ST_DATA) begin
        csum     <= csum ^ rx_byte;
        word_sr  <= {word_sr[15:0], rx_byte};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          wr_en   <= 1'b1;
          wr_data <= {word_sr, rx_byte};
        end
      end

      if (wr_en) begin
        wr_addr      <= wr_addr + ADDR_W'(4);
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned CPB     = 8;
  localparam int unsigned TIMEOUT = 2000;

  logic        clock;
  logic        reset;
  logic        rx;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err;
  logic [15:0] words_loaded;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [127:0] frm;   // bytes left-justified, first byte in [127:120]
    int unsigned  n;
    logic         exp_done;
    logic         exp_err;
    logic [15:0]  exp_words;
    logic [15:0]  exp_addr;
    int unsigned  nwr;
    logic [31:0]  wd0;
    logic [31:0]  wd1;
  } vec_t;
  vec_t vecs[7];

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (16),
    .BASE_ADDR   (0),
    .MAX_WORDS   (256),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every observed write is matched against the queue head
  always @(negedge clock) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'h0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {16'h0, wr_addr}, {16'h0, e.addr});
        check("write_data", wr_data, e.data);
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic settle();
    repeat (3 * CPB) @(negedge clock);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic b, input logic [15:0] w);
    check({tag, "_done"},  {31'h0, done}, {31'h0, d});
    check({tag, "_err"},   {31'h0, err},  {31'h0, e});
    check({tag, "_busy"},  {31'h0, busy}, {31'h0, b});
    check({tag, "_words"}, {16'h0, words_loaded}, {16'h0, w});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{frm: {96'hA5000220080005000000002D, 32'h0}, n: 12, exp_done: 1'b1, exp_err: 1'b0,
                exp_words: 16'd2, exp_addr: 16'd8, nwr: 2, wd0: 32'h20080005, wd1: 32'h0};
    vecs[1] = '{frm: {96'hA5000220080005000000002C, 32'h0}, n: 12, exp_done: 1'b0, exp_err: 1'b1,
                exp_words: 16'd2, exp_addr: 16'd8, nwr: 2, wd0: 32'h20080005, wd1: 32'h0};
    vecs[2] = '{frm: {32'hA5000000, 96'h0}, n: 4, exp_done: 1'b1, exp_err: 1'b0,
                exp_words: 16'd0, exp_addr: 16'd0, nwr: 0, wd0: 32'h0, wd1: 32'h0};
    vecs[3] = '{frm: {32'hA5000001, 96'h0}, n: 4, exp_done: 1'b0, exp_err: 1'b1,
                exp_words: 16'd0, exp_addr: 16'd0, nwr: 0, wd0: 32'h0, wd1: 32'h0};
    vecs[4] = '{frm: {24'hA50101, 104'h0}, n: 3, exp_done: 1'b0, exp_err: 1'b1,
                exp_words: 16'd0, exp_addr: 16'd0, nwr: 0, wd0: 32'h0, wd1: 32'h0};
    vecs[5] = '{frm: {72'h11A50001DEADBEEF22, 56'h0}, n: 9, exp_done: 1'b1, exp_err: 1'b0,
                exp_words: 16'd1, exp_addr: 16'd4, nwr: 1, wd0: 32'hDEADBEEF, wd1: 32'h0};
    vecs[6] = '{frm: {64'hA50001A5A5A5A500, 64'h0}, n: 8, exp_done: 1'b1, exp_err: 1'b0,
                exp_words: 16'd1, exp_addr: 16'd4, nwr: 1, wd0: 32'hA5A5A5A5, wd1: 32'h0};

    rx    = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_status("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset_wr_en",   {31'h0, wr_en}, 32'h0);
    check("reset_wr_addr", {16'h0, wr_addr}, 32'h0);
    check("reset_wr_data", wr_data, 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].nwr > 0) push_wr(16'd0, vecs[i].wd0);
      if (vecs[i].nwr > 1) push_wr(16'd4, vecs[i].wd1);
      for (int j = 0; j < int'(vecs[i].n); j++)
        send_byte(vecs[i].frm[127 - 8*j -: 8], 1'b1);
      settle();
      check_status($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, 1'b0,
                   vecs[i].exp_words);
      check($sformatf("vec%0d_addr", i), {16'h0, wr_addr}, {16'h0, vecs[i].exp_addr});
      check($sformatf("vec%0d_sb_empty", i), exp_q.size(), 0);
    end

    // stop bit low on first data byte, then a good frame recovers
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    check_status("mid_busy", 1'b0, 1'b0, 1'b1, 16'd0);
    send_byte(8'h12, 1'b0);
    settle();
    check_status("stop_err", 1'b0, 1'b1, 1'b0, 16'd0);
    push_wr(16'd0, 32'hDEADBEEF);
    foreach (vecs[5].frm[k]) begin end
    for (int j = 1; j < 9; j++) send_byte(vecs[5].frm[127 - 8*j -: 8], 1'b1);
    settle();
    check_status("recover", 1'b1, 1'b0, 1'b0, 16'd1);

    // stall after two data bytes
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check_status("stall_busy", 1'b0, 1'b0, 1'b1, 16'd0);
    repeat (TIMEOUT + 300) @(negedge clock);
    check_status("timeout", 1'b0, 1'b1, 1'b0, 16'd0);

    // reset in the middle of the second word
    push_wr(16'd0, 32'h01020304);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("pre_reset_addr", {16'h0, wr_addr}, 32'd4);
    #2 reset = 1'b0;
    #1;
    check_status("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
    check("async_rst_addr", {16'h0, wr_addr}, 32'h0);
    check("async_rst_data", wr_data, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    push_wr(16'd0, 32'hDEADBEEF);
    for (int j = 1; j < 9; j++) send_byte(vecs[5].frm[127 - 8*j -: 8], 1'b1);
    settle();
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 16'd1);

    // quarter-bit glitch between header and length must not become a byte
    push_wr(16'd0, 32'hDEADBEEF);
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    for (int j = 2; j < 9; j++) send_byte(vecs[5].frm[127 - 8*j -: 8], 1'b1);
    settle();
    check_status("glitch", 1'b1, 1'b0, 1'b0, 16'd1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
